div_unit: RTL and testbench

//  Multi-cycle 32-bit signed/unsigned restoring divider serving the EX stage for DIV/DIVU.

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_step.sv | 47 ++++
 rtl/div_unit.sv | 200 ++++++++++++++++++++
 tb/tb_div_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg -- shared definitions for the multi-cycle divider.
//
// Contents:
//   DIV_DATA_W            default operand width
//   div_state_e           2-bit FSM state codes (FREE, BYZERO, ON, END)
//   DIV_RESULT_READY /
//   DIV_RESULT_NOT_READY  ready_o encodings
//   DIV_START             start_i "request asserted" level
//
// Optional feature macro used by div_unit: DIV_EARLY_OUT_EN
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step -- one combinational restoring-division iteration.
//
// The pair {rem_i, quo_i} is treated as one 2*DATA_W shift register: the top
// dividend bit of quo_i shifts into the partial remainder, a trial subtract
// against the divisor is made, and the resulting quotient bit shifts into the
// bottom of quo_o (so quo_o[0] is this iteration's quotient bit).
//
// Ports:
//   rem_i      in  DATA_W  partial remainder (always < divisor_i)
//   quo_i      in  DATA_W  remaining dividend bits / quotient bits so far
//   divisor_i  in  DATA_W  divisor magnitude (nonzero)
//   rem_o      out DATA_W  updated partial remainder
//   quo_o      out DATA_W  shifted quotient, new bit in [0]
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    // One extra bit so the shifted remainder (< 2*divisor) never overflows and
    // the borrow of the trial subtraction shows up in the MSB.
    logic [DATA_W:0] shifted_s;
    logic [DATA_W:0] diff_s;
    logic            q_bit_s;

    // Shift, trial subtract, keep the difference only when it did not borrow.
    always_comb begin
        shifted_s = {rem_i, quo_i[DATA_W-1]};
        diff_s    = shifted_s - {1'b0, divisor_i};
        q_bit_s   = ~diff_s[DATA_W];
        if (q_bit_s) begin
            rem_o = diff_s[DATA_W-1:0];
        end else begin
            rem_o = shifted_s[DATA_W-1:0];
        end
        quo_o = {quo_i[DATA_W-2:0], q_bit_s};
    end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multi-cycle 32-bit signed/unsigned restoring divider (DIV/DIVU).
//
// One quotient bit per cycle. Operands are captured on the accepting edge;
// signed requests are divided as magnitudes and sign-corrected at the end
// (quotient negative when signs differ, remainder takes the dividend's sign).
// -2^(W-1) / -1 wraps to quotient 0x80000000, remainder 0.
//
// Latency from the accepting edge to ready_o: DATA_W+2 (normal), 2 (divide
// by zero, result 0), 1 (early-out, when enabled).
//
// Ports:
//   clk           in   1         clock
//   rst           in   1         synchronous reset, active-high
//   signed_div_i  in   1         1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     in   DATA_W    dividend
//   opdata2_i     in   DATA_W    divisor
//   start_i       in   1         request level, held until ready_o seen
//   annul_i       in   1         flush; cancels any operation in flight
//   result_o      out  2*DATA_W  {remainder, quotient}, registered
//   ready_o       out  1         result valid, registered
//
// Configuration macro: DIV_EARLY_OUT_EN -- when defined, an accepted request
// whose |divisor| exceeds |dividend| skips the iteration loop and completes
// with quotient 0, remainder = dividend. Results are identical either way.
// -----------------------------------------------------------------------------
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int                CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);

    div_state_e              state_q,   state_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [DATA_W-1:0]       rem_q,     rem_d;
    logic [DATA_W-1:0]       quo_q,     quo_d;
    logic [DATA_W-1:0]       divisor_q, divisor_d;
    logic                    quo_neg_q, quo_neg_d;
    logic                    rem_neg_q, rem_neg_d;
    logic                    ready_q,   ready_d;
    logic [2*DATA_W-1:0]     result_q,  result_d;

    logic                    op1_neg_s;
    logic                    op2_neg_s;
    logic [DATA_W-1:0]       op1_abs_s;
    logic [DATA_W-1:0]       op2_abs_s;
    logic                    early_s;
    logic [DATA_W-1:0]       step_rem_s;
    logic [DATA_W-1:0]       step_quo_s;

    // Two's complement negate when requested; used for both operand
    // magnitudes and the final sign fix-up.
    function automatic logic [DATA_W-1:0] neg_if(input logic neg,
                                                 input logic [DATA_W-1:0] v);
        if (neg) begin
            return {DATA_W{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem_s),
        .quo_o     (step_quo_s)
    );

    // Operand magnitudes and signs; -2^(W-1) maps onto itself, which is the
    // correct unsigned magnitude.
    always_comb begin
        op1_neg_s = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg_s = signed_div_i & opdata2_i[DATA_W-1];
        op1_abs_s = neg_if(op1_neg_s, opdata1_i);
        op2_abs_s = neg_if(op2_neg_s, opdata2_i);
`ifdef DIV_EARLY_OUT_EN
        early_s   = (op2_abs_s > op1_abs_s);
`else
        early_s   = 1'b0;
`endif
    end

    // FSM next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        ready_d   = DIV_RESULT_NOT_READY;
        result_d  = {(2*DATA_W){1'b0}};

        case (state_q)
            DIV_FREE: begin
                if ((start_i == DIV_START) && !annul_i) begin
                    divisor_d = op2_abs_s;
                    quo_neg_d = op1_neg_s ^ op2_neg_s;
                    rem_neg_d = op1_neg_s;
                    cnt_d     = {CNT_W{1'b0}};
                    if (opdata2_i == {DATA_W{1'b0}}) begin
                        // Zero working registers make the END fix-up yield 0.
                        state_d = DIV_BYZERO;
                        rem_d   = {DATA_W{1'b0}};
                        quo_d   = {DATA_W{1'b0}};
                    end else if (early_s) begin
                        // Magnitude remainder + dividend sign restores the
                        // original signed dividend at END.
                        state_d = DIV_END;
                        rem_d   = op1_abs_s;
                        quo_d   = {DATA_W{1'b0}};
                    end else begin
                        state_d = DIV_ON;
                        rem_d   = {DATA_W{1'b0}};
                        quo_d   = op1_abs_s;
                    end
                end else begin
                    state_d = DIV_FREE;
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DIV_END;
                end else begin
                    rem_d = step_rem_s;
                    quo_d = step_quo_s;
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DIV_END: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (start_i == DIV_START) begin
                    state_d  = DIV_END;
                    ready_d  = DIV_RESULT_READY;
                    result_d = {neg_if(rem_neg_q, rem_q), neg_if(quo_neg_q, quo_q)};
                end else begin
                    state_d = DIV_FREE;
                end
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= {CNT_W{1'b0}};
            rem_q     <= {DATA_W{1'b0}};
            quo_q     <= {DATA_W{1'b0}};
            divisor_q <= {DATA_W{1'b0}};
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            ready_q   <= DIV_RESULT_NOT_READY;
            result_q  <= {(2*DATA_W){1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- scoreboard bench for div_unit.
// The driver issues requests and pushes the expected {rem, quo} and latency;
// a monitor sampling on the falling edge pops and compares whenever ready_o
// rises, and checks hold/drop behaviour and the reset state.
// Honours DIV_EARLY_OUT_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          signed_div_i = 1'b0;
    logic [W-1:0]  opdata1_i = '0;
    logic [W-1:0]  opdata2_i = '0;
    logic          start_i = 1'b0;
    logic          annul_i = 1'b0;
    logic [2*W-1:0] result_o;
    logic          ready_o;

    typedef struct {
        logic [2*W-1:0] res;
        int             lat;
        int             acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic rst_at_edge = 1'b0;
    bit   done = 1'b0;
    bit   mon_done = 1'b0;

    div_unit #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    // Reference: plain integer division (C-style truncation), with the
    // divide-by-zero and most-negative/-1 cases taken from the rules directly.
    function automatic logic [2*W-1:0] ref_div(input bit sgn, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int sa, sb, q, r;
        logic [W-1:0] qq, rr;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = a; sb = b;
            q = sa / sb;
            r = sa % sb;
            qq = q; rr = r;
            return {rr, qq};
        end
        return {a % b, a / b};
    endfunction

    function automatic int ref_lat(input bit sgn, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        logic [W-1:0] ma, mb;
        ma = (sgn && a[W-1]) ? (32'd0 - a) : a;
        mb = (sgn && b[W-1]) ? (32'd0 - b) : b;
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (mb > ma) return 1;
`else
        if (mb > ma) return W + 2;
`endif
        return W + 2;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = $urandom_range(0, 20);
            4: v = 32'd0 - $urandom_range(1, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Called at posedge+2. Issues a request, scrambles inputs after
    // acceptance, waits (bounded) for ready_o, holds, then drops start_i.
    task automatic do_req(input bit sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        exp_t e;
        bit   seen;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk); #2;
        e.res = ref_div(sgn, a, b);
        e.lat = ref_lat(sgn, a, b);
        e.acc = cyc;
        sb_q.push_back(e);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ready_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        if (!seen) begin
            $display("FAIL ready_timeout: ready_o low after 60 cycles for %h/%h, required high", a, b);
            $fatal(1, "ready timeout");
        end
        repeat (hold) begin
            @(posedge clk); #2;
        end
        start_i = 1'b0;
        @(posedge clk); #2;
    endtask

    // Monitor / scoreboard: all comparisons happen here on the falling edge.
    initial begin : monitor
        bit   ready_prev;
        bit   start_prev;
        exp_t cur;
        ready_prev = 1'b0;
        start_prev = 1'b0;
        cur.res = '0; cur.lat = 0; cur.acc = 0;
        forever begin
            @(negedge clk);
            if (rst_at_edge === 1'b1) begin
                n_cmp++;
                if (ready_o !== 1'b0 || result_o !== 64'd0) begin
                    n_err++;
                    $display("FAIL reset_state: ready=%b result=%h, required 0 and 0", ready_o, result_o);
                end
            end else begin
                if (ready_o === 1'b1 && !ready_prev) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_ready: result=%h, required no ready", result_o);
                    end else begin
                        cur = sb_q.pop_front();
                        n_cmp++;
                        if (result_o !== cur.res) begin
                            n_err++;
                            $display("FAIL result: got %h, required %h", result_o, cur.res);
                        end
                        n_cmp++;
                        if (cyc - cur.acc != cur.lat) begin
                            n_err++;
                            $display("FAIL latency: got %0d, required %0d", cyc - cur.acc, cur.lat);
                        end
                    end
                end else if (ready_o === 1'b1 && ready_prev) begin
                    n_cmp++;
                    if (result_o !== cur.res) begin
                        n_err++;
                        $display("FAIL result_hold: got %h, required %h", result_o, cur.res);
                    end
                end
                if (ready_prev && !start_prev) begin
                    n_cmp++;
                    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
                        n_err++;
                        $display("FAIL drop: ready=%b result=%h, required 0 and 0", ready_o, result_o);
                    end
                end
            end
            ready_prev = (ready_o === 1'b1);
            start_prev = start_i;
            if (done && !mon_done) begin
                n_cmp++;
                if (sb_q.size() != 0) begin
                    n_err++;
                    $display("FAIL leftover: %0d results never returned, required 0", sb_q.size());
                end
                mon_done = 1'b1;
            end
        end
    end

    // Driver: directed cases first, then randomized requests.
    initial begin : driver
        bit           sgn;
        logic [W-1:0] a, b;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk); #2;

        do_req(1'b0, 32'd100, 32'd7, 3);
        do_req(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
        do_req(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_req(1'b0, 32'd5, 32'd0, 1);

        // Annul mid-operation; a new request on the following cycle.
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk); #2;
        repeat (9) begin
            @(posedge clk); #2;
        end
        annul_i = 1'b1;
        @(posedge clk); #2;
        annul_i = 1'b0;
        do_req(1'b0, 32'd9, 32'd3, 1);

        // Reset during the iteration loop; no stale result afterwards.
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk); #2;
        repeat (5) begin
            @(posedge clk); #2;
        end
        rst = 1'b1; start_i = 1'b0;
        repeat (2) begin
            @(posedge clk); #2;
        end
        rst = 1'b0;
        do_req(1'b0, 32'hFFFF_FFFF, 32'd1, 1);

        do_req(1'b0, 32'd3, 32'd10, 1);
        do_req(1'b1, 32'hFFFF_FFFD, 32'd10, 0);
        do_req(1'b1, 32'd7, 32'hFFFF_FFFE, 2);

        for (int n = 0; n < 30; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = pick();
            b   = pick();
            do_req(sgn, a, b, $urandom_range(0, 2));
        end

        done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (mon_done) break;
            @(posedge clk); #2;
        end
        if (!mon_done) begin
            $display("FAIL monitor_stall: monitor did not finish, required finish");
            $fatal(1, "monitor stall");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
